// File: rtl/fetch_aligner.sv
// Fetch aligner: splits word-aligned 32-bit fetch words into 16/32-bit instructions on
// halfword boundaries and presents one per cycle through a registered valid/ready output.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_data_i,
    output logic        fetch_ready_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic        inst_compressed_o,
    output logic [31:0] inst_pc_o
);

    logic [31:0] word_addr_r;
    logic        skip_r;
    logic        buf_valid_r;
    logic [15:0] buf_hw_r;
    logic [31:0] buf_pc_r;
    logic        inst_valid_r;
    logic [31:0] inst_r;
    logic        inst_c_r;
    logic [31:0] inst_pc_r;

    logic        out_free_s;
    logic        step_s;
    logic        buf_c_s;
    logic        consume_s;
    logic [31:0] addr_hi_s;
    logic        load_s;
    logic [31:0] nxt_inst_s;
    logic [31:0] nxt_pc_s;
    logic        buf_load_s;
    logic        buf_clr_s;
    logic [15:0] nxt_buf_hw_s;
    logic [31:0] nxt_buf_pc_s;
    logic        skip_clr_s;
    logic        unused_pc_bit_s;

    assign unused_pc_bit_s = redirect_pc_i[0];

    assign out_free_s    = !inst_valid_r || inst_ready_i;
    assign step_s        = out_free_s && !redirect_i;
    assign buf_c_s       = buf_valid_r && (buf_hw_r[1:0] != 2'b11);
    assign fetch_ready_o = step_s && !buf_c_s;
    assign consume_s     = fetch_valid_i && fetch_ready_o;
    assign addr_hi_s     = word_addr_r + 32'd2;

    assign fetch_addr_o      = word_addr_r;
    assign inst_valid_o      = inst_valid_r;
    assign inst_o            = inst_r;
    assign inst_compressed_o = inst_c_r;
    assign inst_pc_o         = inst_pc_r;

    // Select this cycle's step: output load, buffer update and skip clear.
    always_comb begin
        load_s       = 1'b0;
        nxt_inst_s   = 32'h0000_0000;
        nxt_pc_s     = 32'h0000_0000;
        buf_load_s   = 1'b0;
        buf_clr_s    = 1'b0;
        nxt_buf_hw_s = 16'h0000;
        nxt_buf_pc_s = 32'h0000_0000;
        skip_clr_s   = 1'b0;
        if (!step_s) begin
            load_s = 1'b0;
        end else if (buf_c_s) begin
            load_s     = 1'b1;
            nxt_inst_s = {16'h0000, buf_hw_r};
            nxt_pc_s   = buf_pc_r;
            buf_clr_s  = 1'b1;
        end else if (buf_valid_r) begin
            if (fetch_valid_i) begin
                // Upper half of a straddling instruction completes from the new word.
                load_s       = 1'b1;
                nxt_inst_s   = {fetch_data_i[15:0], buf_hw_r};
                nxt_pc_s     = buf_pc_r;
                buf_load_s   = 1'b1;
                nxt_buf_hw_s = fetch_data_i[31:16];
                nxt_buf_pc_s = addr_hi_s;
            end else begin
                load_s = 1'b0;
            end
        end else if (fetch_valid_i) begin
            if (skip_r) begin
                skip_clr_s = 1'b1;
                if (fetch_data_i[17:16] != 2'b11) begin
                    load_s     = 1'b1;
                    nxt_inst_s = {16'h0000, fetch_data_i[31:16]};
                    nxt_pc_s   = addr_hi_s;
                end else begin
                    buf_load_s   = 1'b1;
                    nxt_buf_hw_s = fetch_data_i[31:16];
                    nxt_buf_pc_s = addr_hi_s;
                end
            end else if (fetch_data_i[1:0] == 2'b11) begin
                load_s     = 1'b1;
                nxt_inst_s = fetch_data_i;
                nxt_pc_s   = word_addr_r;
            end else begin
                load_s       = 1'b1;
                nxt_inst_s   = {16'h0000, fetch_data_i[15:0]};
                nxt_pc_s     = word_addr_r;
                buf_load_s   = 1'b1;
                nxt_buf_hw_s = fetch_data_i[31:16];
                nxt_buf_pc_s = addr_hi_s;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Aligner state and registered output; redirect overrides any step or backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_addr_r  <= {RESET_PC[31:2], 2'b00};
            skip_r       <= RESET_PC[1];
            buf_valid_r  <= 1'b0;
            buf_hw_r     <= 16'h0000;
            buf_pc_r     <= 32'h0000_0000;
            inst_valid_r <= 1'b0;
            inst_r       <= 32'h0000_0000;
            inst_c_r     <= 1'b0;
            inst_pc_r    <= 32'h0000_0000;
        end else if (redirect_i) begin
            word_addr_r  <= {redirect_pc_i[31:2], 2'b00};
            skip_r       <= redirect_pc_i[1];
            buf_valid_r  <= 1'b0;
            inst_valid_r <= 1'b0;
        end else begin
            if (consume_s) begin
                word_addr_r <= word_addr_r + 32'd4;
            end
            if (skip_clr_s) begin
                skip_r <= 1'b0;
            end
            if (buf_load_s) begin
                buf_valid_r <= 1'b1;
                buf_hw_r    <= nxt_buf_hw_s;
                buf_pc_r    <= nxt_buf_pc_s;
            end else if (buf_clr_s) begin
                buf_valid_r <= 1'b0;
            end
            if (load_s) begin
                inst_valid_r <= 1'b1;
                inst_r       <= nxt_inst_s;
                inst_c_r     <= (nxt_inst_s[1:0] != 2'b11);
                inst_pc_r    <= nxt_pc_s;
            end else if (inst_ready_i) begin
                inst_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: directed scenarios plus random traffic, every accepted
// instruction checked against an instruction-stream model over a word memory.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] fetch_addr_o;
    logic        fetch_valid_i;
    logic [31:0] fetch_data_i;
    logic        fetch_ready_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic        inst_compressed_o;
    logic [31:0] inst_pc_o;

    logic [31:0] mem [256];
    assign fetch_data_i = mem[fetch_addr_o[9:2]];

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .fetch_addr_o(fetch_addr_o), .fetch_valid_i(fetch_valid_i),
        .fetch_data_i(fetch_data_i), .fetch_ready_o(fetch_ready_o),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_compressed_o(inst_compressed_o), .inst_pc_o(inst_pc_o)
    );

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    int          n_out      = 0;
    int          n_words    = 0;
    int          n0;
    int          w0;
    logic [31:0] exp_pc;
    logic        hold_pending;
    logic [31:0] held_inst;
    logic [31:0] held_pc;
    logic        held_c;
    logic        fr_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction at a halfword address of the program image.
    function automatic logic [31:0] ref_inst(input logic [31:0] pc);
        logic [15:0] lo;
        lo = hw(pc);
        if (lo[1:0] == 2'b11) return {hw(pc + 32'd2), lo};
        else return {16'h0000, lo};
    endfunction

    // One clock: drive inputs just after the edge, check mid-cycle, advance to next edge.
    task automatic step(input logic fv, input logic rdy, input logic rd, input logic [31:0] rpc);
        logic [31:0] e;
        fetch_valid_i = fv;
        inst_ready_i  = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        #4;
        fr_seen = fetch_ready_o;
        chk("addr_align", {30'd0, fetch_addr_o[1:0]}, 32'd0);
        if (hold_pending) begin
            chk("hold_valid", {31'd0, inst_valid_o}, 32'd1);
            chk("hold_inst", inst_o, held_inst);
            chk("hold_pc", inst_pc_o, held_pc);
            chk("hold_c", {31'd0, inst_compressed_o}, {31'd0, held_c});
        end
        if (inst_valid_o && !rdy) chk("bp_fetch_ready", {31'd0, fetch_ready_o}, 32'd0);
        if (rd) chk("rd_fetch_ready", {31'd0, fetch_ready_o}, 32'd0);
        if (inst_valid_o && rdy && !rd) begin
            e = ref_inst(exp_pc);
            chk("inst", inst_o, e);
            chk("pc", inst_pc_o, exp_pc);
            chk("compressed", {31'd0, inst_compressed_o}, {31'd0, (e[1:0] != 2'b11)});
            exp_pc = exp_pc + ((e[1:0] != 2'b11) ? 32'd2 : 32'd4);
            n_out++;
        end
        if (fv && fetch_ready_o) n_words++;
        hold_pending = inst_valid_o && !rdy && !rd;
        held_inst = inst_o;
        held_pc   = inst_pc_o;
        held_c    = inst_compressed_o;
        if (rd) exp_pc = {rpc[31:1], 1'b0};
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'd0;
        fetch_valid_i = 1'b0; inst_ready_i = 1'b0;
        hold_pending = 1'b0; exp_pc = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_pc", inst_pc_o, 32'd0);
        chk("rst_c", {31'd0, inst_compressed_o}, 32'd0);
        chk("rst_addr", fetch_addr_o, 32'd0);
        rst = 1'b0;

        // 32-bit instruction at 0: one cycle latency, next fetch at 4.
        mem[0] = 32'h00A0_0093;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t1_ready", {31'd0, fr_seen}, 32'd1);
        chk("t1_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t1_addr", fetch_addr_o, 32'd4);
        n0 = n_out;
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("t1_nout", n_out - n0, 32'd1);

        // Two compressed in one word, consecutive, second without a fetch.
        mem[0] = 32'h0001_4505;
        step(1'b0, 1'b1, 1'b1, 32'd0);
        n0 = n_out; w0 = n_words;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t2_ready_2nd", {31'd0, fr_seen}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("t2_nout", n_out - n0, 32'd2);
        chk("t2_words", n_words - w0, 32'd1);

        // Straddle across words 0 and 4.
        mem[0] = 32'h0093_4505;
        mem[1] = 32'h4505_00A0;
        step(1'b0, 1'b1, 1'b1, 32'd0);
        n0 = n_out;
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t3_nout", n_out - n0, 32'd3);

        // Straddle with the second word stalled 3 cycles.
        step(1'b0, 1'b1, 1'b1, 32'd0);
        n0 = n_out;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("t4_stall_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("t4_stall_nout", n_out - n0, 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t4_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("t4_inst", inst_o, 32'h00A0_0093);
        step(1'b0, 1'b1, 1'b0, 32'd0);

        // Redirect to 0x102: skip the low half.
        mem[64] = 32'h0001_4505;
        step(1'b0, 1'b1, 1'b1, 32'h0000_0102);
        chk("t5_addr", fetch_addr_o, 32'h0000_0100);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t5_inst", inst_o, 32'h0000_0001);
        chk("t5_pc", inst_pc_o, 32'h0000_0102);
        chk("t5_c", {31'd0, inst_compressed_o}, 32'd1);
        chk("t5_addr2", fetch_addr_o, 32'h0000_0104);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("t5_single", {31'd0, inst_valid_o}, 32'd0);

        // Backpressure for 3 cycles, then drain with fetches flowing.
        step(1'b0, 1'b1, 1'b1, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        w0 = n_words;
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("t6_no_fetch", n_words - w0, 32'd0);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect while the buffer holds the low half of a 32-bit instruction.
        mem[0]  = 32'h0093_4505;
        mem[64] = 32'h00A0_0093;
        step(1'b0, 1'b1, 1'b1, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        chk("t7_valid", {31'd0, inst_valid_o}, 32'd0);
        n0 = n_out;
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("t7_nout", (n_out - n0 >= 1) ? 32'd1 : 32'd0, 32'd1);

        // Straddle across the address wrap.
        mem[255] = 32'h0093_0000;
        mem[0]   = 32'h0001_00A0;
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("wrap_addr", fetch_addr_o, 32'd0);
        chk("wrap_nooutput", {31'd0, inst_valid_o}, 32'd0);
        n0 = n_out;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'd0);
        chk("wrap_nout", n_out - n0, 32'd2);

        // Asynchronous reset in the middle of traffic.
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
        rst = 1'b1;
        #1;
        chk("mrst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("mrst_inst", inst_o, 32'd0);
        chk("mrst_addr", fetch_addr_o, 32'd0);
        fetch_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_pc = 32'd0;
        hold_pending = 1'b0;

        // Random program image, handshakes and redirects.
        for (int i = 0; i < 256; i++) mem[i] = $urandom();
        step(1'b0, 1'b1, 1'b1, $urandom());
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Upstream neighbour of the RVC decompressor in the IF stage.
- Consumes word-aligned 32-bit fetch words from the I-cache.
- Extracts instructions on halfword boundaries: 16-bit compressed, or 32-bit including words that straddle two fetch words.
- Presents one raw instruction per cycle, with its PC and a compressed flag, through a registered valid/ready output. The decompressor and decode stage consume it.

Parameters:
RESET_PC, 32'h0000_0000, PC after reset (bit 0 ignored, bit 1 honoured)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
redirect_i  input  1  branch/jump/exception redirect, highest priority
redirect_pc_i  input  32  redirect target (bit 0 ignored)
fetch_addr_o  output  32  word address of the fetch word needed next, [1:0]=00
fetch_valid_i  input  1  fetch_data_i holds the word at fetch_addr_o this cycle
fetch_data_i  input  32  fetch word, little-endian halfwords
fetch_ready_o  output  1  word consumed this cycle
inst_valid_o  output  1  output instruction valid
inst_ready_i  input  1  downstream accepts
inst_o  output  32  raw instruction; compressed ones zero-extended in [31:16]
inst_compressed_o  output  1  inst_o[1:0] != 2'b11
inst_pc_o  output  32  PC of inst_o

Behaviour:
- Reset is asynchronous and active-high on rst, single clock clk.
- Reset values:
  - inst_valid_o=0, inst_o=0, inst_compressed_o=0, inst_pc_o=0.
  - Halfword buffer empty.
  - fetch_addr_o={RESET_PC[31:2],2'b00}.
  - skip flag = RESET_PC[1].
- State:
  - word_addr (drives fetch_addr_o).
  - buf_valid, buf_hw[15:0], buf_pc[31:0].
  - skip (discard low half of the next word).
- out_free = !inst_valid_o || inst_ready_i.
- A step executes only when out_free and !redirect_i. Exactly one case applies per cycle:
  - A. buf_valid, buf_hw[1:0]!=11:
    - Output buf_hw as compressed, pc buf_pc.
    - buf_valid<=0. No word consumed.
  - B. buf_valid, buf_hw 32-bit, fetch_valid_i:
    - Output {w[15:0],buf_hw}, pc buf_pc.
    - buf_hw<=w[31:16], buf_pc<=word_addr+2.
    - Word consumed.
  - C. !buf_valid, skip, fetch_valid_i:
    - skip<=0; word consumed.
    - If w[17:16]!=11: output w[31:16] compressed, pc word_addr+2.
    - Else: load buffer with w[31:16], pc word_addr+2, no output this cycle.
  - D. !buf_valid, !skip, fetch_valid_i:
    - If w[1:0]==11: output w, pc word_addr, word consumed.
    - Else: output w[15:0] compressed, pc word_addr; buffer<=w[31:16], pc word_addr+2; word consumed.
  - Otherwise: no output load. inst_valid_o<=0 if inst_ready_i.
- fetch_ready_o = out_free && !redirect_i && !(buf_valid && buf_hw[1:0]!=11).
  - Combinational, independent of fetch_valid_i.
  - A word is consumed iff fetch_valid_i && fetch_ready_o.
- Consumed word: word_addr<=word_addr+4, wrapping modulo 2^32.
- Output register:
  - Loads on any step producing output; inst_valid_o<=1.
  - Held stable (all output fields) while inst_valid_o && !inst_ready_i.
- Latency: 1 cycle from word consumption to inst_valid_o.
- Throughput: 1 instruction/cycle sustained. Two compressed instructions per word are emitted on consecutive cycles, the second without a fetch.
- Redirect (any cycle, overrides step and backpressure):
  - inst_valid_o<=0, buf_valid<=0.
  - word_addr<={redirect_pc_i[31:2],2'b00}, skip<=redirect_pc_i[1].
  - Word presented in the redirect cycle is not consumed.
- Reset asserted mid-operation: all state returns immediately to reset values, regardless of handshakes in flight.
- Boundaries:
  - 32-bit instruction at word_addr+2 with the next word stalled: buffer holds, no output, until fetch_valid_i.
  - Wrap 0xFFFF_FFFC -> 0x0000_0000 is legal, with no special handling.

Test Plan:
- Reset with RESET_PC=0; word@0=0x00A00093 -> inst_o=0x00A00093, pc=0, compressed=0, valid 1 cycle after consumption; fetch_addr_o becomes 4.
- Word@0=0x00014505 with inst_ready_i=1 -> 0x00004505@0 then 0x00000001@2 on consecutive cycles; fetch_ready_o=0 during the second; one word consumed.
- Straddle: word@0=0x00934505, word@4=0x450500A0 -> 0x00004505@0, 0x00A00093@2, 0x00004505@6.
- Straddle with word@4 stalled 3 cycles (fetch_valid_i=0) -> no output; 0x00A00093@2 one cycle after fetch_valid_i rises.
- Redirect to 0x102; word@0x100=0x00014505 -> fetch_addr_o=0x100; single output 0x00000001@0x102, compressed=1; next fetch_addr_o=0x104.
- Backpressure: inst_ready_i=0 for 3 cycles with valid output -> inst_o/pc stable, fetch_ready_o=0, no words lost.
- Redirect while the buffer holds the half of a 32-bit instruction -> inst_valid_o=0 next cycle, buffer dropped, new stream correct.
